// File: rtl/i2c_sda_ctrl.sv
// i2c_sda_ctrl: open-drain SDA data path for the I2C master.
// Generates START/STOP, shifts address+R/W and write bytes MSB-first,
// samples ACK and read data, and owns the per-byte bit counter.
//
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   state_master[3:0] - master FSM state (Idle=0 .. Stop=11)
//   count_ctrl[6:0]   - SCL phase counter, 0..T_LOW+T_HIGH-1 per bit
//   addr[6:0], rw     - target address and read flag, captured in Idle
//   wdata[7:0]        - write byte, captured on entry to Write_Data
//   sda_in            - pad SDA level
//   sda_oe            - 1 pulls SDA low, 0 releases it
//   count[3:0]        - bit index within the current byte
//   rdata[7:0]        - last received byte, rdata_valid strobes on update
//   ack_ok            - result of the last Check_ACK (1 = ACK)
//   nack              - one-cycle strobe when a NACK is sampled
//
// Optional build macro: I2C_SDA_GLITCH_FILTER_EN adds a 2-of-3 majority
// filter after the synchronizer (3-cycle pad-to-sample latency).
module i2c_sda_ctrl #(
  parameter int unsigned T_LOW     = 6,
  parameter int unsigned T_HIGH    = 4,
  parameter int unsigned THRESHOLD = 2,
  parameter int unsigned DATA_LEN  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] state_master,
  input  logic [6:0] count_ctrl,
  input  logic [6:0] addr,
  input  logic       rw,
  input  logic [7:0] wdata,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [3:0] count,
  output logic [7:0] rdata,
  output logic       rdata_valid,
  output logic       ack_ok,
  output logic       nack
);

  localparam logic [3:0] ST_IDLE       = 4'd0;
  localparam logic [3:0] ST_READY      = 4'd1;
  localparam logic [3:0] ST_SEND_ADDR  = 4'd2;
  localparam logic [3:0] ST_WRITE_DATA = 4'd3;
  localparam logic [3:0] ST_CHECK_ACK  = 4'd5;
  localparam logic [3:0] ST_READ_DATA  = 4'd6;
  localparam logic [3:0] ST_SEND_ACK   = 4'd9;
  localparam logic [3:0] ST_SEND_NACK  = 4'd10;
  localparam logic [3:0] ST_STOP       = 4'd11;

  localparam logic [6:0] DRIVE_PT    = 7'(T_LOW / 2);
  localparam logic [6:0] SAMPLE_PT   = 7'(T_LOW + T_HIGH / 2);
  localparam logic [6:0] END_PT      = 7'(T_LOW + T_HIGH - 1);
  localparam logic [6:0] STOP_REL_PT = 7'(2 * THRESHOLD + 2);
  localparam logic [3:0] CNT_LAST    = 4'(DATA_LEN - 1);

  logic [3:0] prev_state_q;
  logic       sda_oe_q, sda_oe_d;
  logic [3:0] count_q, count_d;
  logic [7:0] shreg_q, shreg_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] rdata_q, rdata_d;
  logic       rdata_valid_q, rdata_valid_d;
  logic       ack_ok_q, ack_ok_d;
  logic       nack_q, nack_d;
  logic       sync1_q, sync2_q;
  logic       sda_s;

  logic       entry;
  logic       at_drive, at_sample, at_end, at_stop_rel;
  logic [7:0] sh_base;
  logic [3:0] cnt_base;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

`ifdef I2C_SDA_GLITCH_FILTER_EN
  logic hist1_q, hist2_q;

  // Majority of the last three synchronized samples rejects 1-cycle glitches.
  assign sda_s = (sync2_q & hist1_q) | (sync2_q & hist2_q) | (hist1_q & hist2_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist1_q <= 1'b0;
      hist2_q <= 1'b0;
    end else begin
      hist1_q <= sync2_q;
      hist2_q <= hist1_q;
    end
  end
`else
  assign sda_s = sync2_q;
`endif

  assign entry       = (state_master != prev_state_q);
  assign at_drive    = (count_ctrl == DRIVE_PT);
  assign at_sample   = (count_ctrl == SAMPLE_PT);
  assign at_end      = (count_ctrl == END_PT);
  assign at_stop_rel = (count_ctrl == STOP_REL_PT);

  // Next-state decode; entry actions feed the same cycle's decode points.
  always_comb begin
    sda_oe_d      = sda_oe_q;
    count_d       = count_q;
    shreg_d       = shreg_q;
    rx_d          = rx_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    ack_ok_d      = ack_ok_q;
    nack_d        = 1'b0;
    sh_base       = shreg_q;
    cnt_base      = count_q;

    case (state_master)
      ST_IDLE: begin
        sda_oe_d = 1'b0;
        shreg_d  = {addr, rw};
        count_d  = 4'd0;
      end
      ST_READY: sda_oe_d = 1'b1;
      ST_SEND_ADDR, ST_WRITE_DATA: begin
        if (state_master == ST_WRITE_DATA && entry) begin
          sh_base  = wdata;
          cnt_base = 4'd0;
        end
        shreg_d = sh_base;
        count_d = cnt_base;
        if (at_drive) sda_oe_d = ~sh_base[7];
        if (at_end) begin
          shreg_d = {sh_base[6:0], 1'b0};
          count_d = sat_inc(cnt_base);
        end
      end
      ST_CHECK_ACK: begin
        if (entry)    count_d  = 4'd0;
        if (at_drive) sda_oe_d = 1'b0;
        if (at_sample) begin
          ack_ok_d = ~sda_s;
          nack_d   = sda_s;
        end
      end
      ST_READ_DATA: begin
        sda_oe_d = 1'b0;
        if (at_sample) rx_d = {rx_q[6:0], sda_s};
        if (at_end) begin
          count_d = sat_inc(count_q);
          // rx already holds the last bit: SAMPLE precedes END.
          if (count_q == CNT_LAST) begin
            rdata_d       = rx_q;
            rdata_valid_d = 1'b1;
          end
        end
      end
      ST_SEND_ACK:  if (at_drive) sda_oe_d = 1'b1;
      ST_SEND_NACK: if (at_drive) sda_oe_d = 1'b0;
      ST_STOP: begin
        if (entry)       sda_oe_d = 1'b1;
        if (at_stop_rel) sda_oe_d = 1'b0;
      end
      default: ;
    endcase
  end

  // State and output registers, plus the 2-flop pad synchronizer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_state_q  <= ST_IDLE;
      sda_oe_q      <= 1'b0;
      count_q       <= 4'd0;
      shreg_q       <= 8'h00;
      rx_q          <= 8'h00;
      rdata_q       <= 8'h00;
      rdata_valid_q <= 1'b0;
      ack_ok_q      <= 1'b0;
      nack_q        <= 1'b0;
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
    end else begin
      prev_state_q  <= state_master;
      sda_oe_q      <= sda_oe_d;
      count_q       <= count_d;
      shreg_q       <= shreg_d;
      rx_q          <= rx_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      ack_ok_q      <= ack_ok_d;
      nack_q        <= nack_d;
      sync1_q       <= sda_in;
      sync2_q       <= sync1_q;
    end
  end

  assign sda_oe      = sda_oe_q;
  assign count       = count_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rdata_valid_q;
  assign ack_ok      = ack_ok_q;
  assign nack        = nack_q;

endmodule

// File: tb/tb_i2c_sda_ctrl.sv
// tb_i2c_sda_ctrl: drives the master state and SCL phase counter through
// directed and randomized I2C transactions and checks the SDA controller
// against expectations derived from the bytes being moved.
module tb_i2c_sda_ctrl;

  localparam int unsigned T_LOW     = 6;
  localparam int unsigned T_HIGH    = 4;
  localparam int unsigned THRESHOLD = 2;
  localparam int unsigned DATA_LEN  = 8;
  localparam int unsigned BIT_LEN   = T_LOW + T_HIGH;
  localparam int unsigned DRIVE     = T_LOW / 2;
  localparam int unsigned SAMPLE    = T_LOW + T_HIGH / 2;
  localparam int unsigned ENDP      = BIT_LEN - 1;
  localparam int unsigned STOP_REL  = 2 * THRESHOLD + 2;

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_READY  = 4'd1;
  localparam logic [3:0] S_ADDR   = 4'd2;
  localparam logic [3:0] S_WRITE  = 4'd3;
  localparam logic [3:0] S_OUTPUT = 4'd4;
  localparam logic [3:0] S_CKACK  = 4'd5;
  localparam logic [3:0] S_READ   = 4'd6;
  localparam logic [3:0] S_STORE  = 4'd7;
  localparam logic [3:0] S_VALID  = 4'd8;
  localparam logic [3:0] S_SACK   = 4'd9;
  localparam logic [3:0] S_SNACK  = 4'd10;
  localparam logic [3:0] S_STOP   = 4'd11;

`ifdef I2C_SDA_GLITCH_FILTER_EN
  localparam bit GLITCH = 1'b1;
`else
  localparam bit GLITCH = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] state_master;
  logic [6:0] count_ctrl;
  logic [6:0] addr;
  logic       rw;
  logic [7:0] wdata;
  logic       sda_in;
  logic       sda_oe;
  logic [3:0] count;
  logic [7:0] rdata;
  logic       rdata_valid;
  logic       ack_ok;
  logic       nack;

  int n_cmp = 0;
  int n_bad = 0;

  i2c_sda_ctrl #(
    .T_LOW(T_LOW), .T_HIGH(T_HIGH), .THRESHOLD(THRESHOLD), .DATA_LEN(DATA_LEN)
  ) dut (
    .clk(clk), .rst(rst), .state_master(state_master), .count_ctrl(count_ctrl),
    .addr(addr), .rw(rw), .wdata(wdata), .sda_in(sda_in),
    .sda_oe(sda_oe), .count(count), .rdata(rdata), .rdata_valid(rdata_valid),
    .ack_ok(ack_ok), .nack(nack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock with the given master state and phase; returns #1 after the edge.
  task automatic step(input logic [3:0] st, input int unsigned cc);
    state_master = st;
    count_ctrl   = 7'(cc);
    @(posedge clk);
    #1;
  endtask

  // Shift a byte out: SDA level per bit equals the data bit, so oe = ~bit.
  task automatic tx_byte(input logic [3:0] st, input logic [7:0] b, input string tag);
    logic e;
    for (int i = 0; i < 8; i++) begin
      for (int c = 0; c < int'(BIT_LEN); c++) begin
        if (c == int'(ENDP)) check({tag, " count@END"}, 32'(count), 32'(i));
        step(st, c);
        if (c == int'(DRIVE)) begin
          e = ~b[7-i];
          check({tag, " sda_oe"}, 32'(sda_oe), 32'(e));
        end
      end
    end
  endtask

  task automatic ack_phase(input logic a);
    logic e;
    sda_in = a;
    for (int c = 0; c < int'(BIT_LEN); c++) begin
      step(S_CKACK, c);
      if (c == int'(DRIVE)) check("ack release", 32'(sda_oe), 32'd0);
      if (c == int'(SAMPLE)) begin
        e = ~a;
        check("ack_ok", 32'(ack_ok), 32'(e));
        check("nack pulse", 32'(nack), 32'(a));
      end
      if (c == int'(SAMPLE) + 1) check("nack clear", 32'(nack), 32'd0);
    end
    sda_in = 1'b1;
  endtask

  task automatic read_phase(input logic [7:0] r, input bit glitch);
    for (int i = 0; i < 8; i++) begin
      for (int c = 0; c < int'(BIT_LEN); c++) begin
        if (c == 0) sda_in = r[7-i];
        if (glitch && c == int'(SAMPLE) - 2) sda_in = ~r[7-i];
        step(S_READ, c);
        sda_in = r[7-i];
        if (c == int'(DRIVE)) check("read release", 32'(sda_oe), 32'd0);
        if (c == int'(ENDP)) begin
          if (i == 7) begin
            check("rdata", 32'(rdata), 32'(r));
            check("rdata_valid set", 32'(rdata_valid), 32'd1);
          end else begin
            check("rdata_valid early", 32'(rdata_valid), 32'd0);
          end
        end
      end
    end
    sda_in = 1'b1;
  endtask

  task automatic resp_phase(input logic send_ack);
    for (int c = 0; c < int'(BIT_LEN); c++) begin
      step(send_ack ? S_SACK : S_SNACK, c);
      if (c == 0) check("rdata_valid 1cyc", 32'(rdata_valid), 32'd0);
      if (c == int'(DRIVE)) check("resp sda_oe", 32'(sda_oe), 32'(send_ack));
    end
    step(S_STORE, 0);
    step(S_VALID, 0);
    check("hold sda_oe", 32'(sda_oe), 32'(send_ack));
  endtask

  task automatic stop_phase();
    for (int c = 0; c < int'(BIT_LEN); c++) begin
      step(S_STOP, c);
      if (c == 0) check("stop entry", 32'(sda_oe), 32'd1);
      if (c == int'(STOP_REL) - 1) check("stop hold", 32'(sda_oe), 32'd1);
      if (c == int'(STOP_REL)) check("stop release", 32'(sda_oe), 32'd0);
    end
  endtask

  task automatic txn(input logic [6:0] a, input logic r_w, input logic [7:0] wd,
                     input logic [7:0] rd, input logic a1, input logic a2,
                     input logic send_ack, input bit glitch);
    logic e;
    addr = a;
    rw   = r_w;
    for (int k = 0; k < 3; k++) step(S_IDLE, 0);
    check("idle sda_oe", 32'(sda_oe), 32'd0);
    check("idle count", 32'(count), 32'd0);
    step(S_READY, 0);
    check("start sda_oe", 32'(sda_oe), 32'd1);
    step(S_READY, 1);
    tx_byte(S_ADDR, {a, r_w}, "addr");
    ack_phase(a1);
    if (!r_w) begin
      step(S_OUTPUT, 0);
      check("output hold", 32'(sda_oe), 32'd0);
      wdata = wd;
      tx_byte(S_WRITE, wd, "write");
      e = ~a1;
      check("ack_ok held", 32'(ack_ok), 32'(e));
      ack_phase(a2);
    end else begin
      read_phase(rd, glitch);
      resp_phase(send_ack);
    end
    stop_phase();
  endtask

  initial begin
    rst          = 1'b1;
    state_master = S_IDLE;
    count_ctrl   = 7'd0;
    addr         = 7'd0;
    rw           = 1'b0;
    wdata        = 8'h00;
    sda_in       = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst sda_oe", 32'(sda_oe), 32'd0);
    check("rst count", 32'(count), 32'd0);
    check("rst rdata", 32'(rdata), 32'd0);
    check("rst rdata_valid", 32'(rdata_valid), 32'd0);
    check("rst ack_ok", 32'(ack_ok), 32'd0);
    check("rst nack", 32'(nack), 32'd0);
    rst = 1'b0;

    // Directed transactions from the byte-level scenarios.
    txn(7'h50, 1'b0, 8'hA5, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    txn(7'h50, 1'b1, 8'h00, 8'h3C, 1'b0, 1'b0, 1'b0, GLITCH);

    // Asynchronous reset mid-byte while SDA is pulled low.
    addr = 7'h11;
    rw   = 1'b0;
    step(S_IDLE, 0);
    step(S_IDLE, 0);
    wdata = 8'h00;
    for (int i = 0; i < 4; i++)
      for (int c = 0; c < int'(BIT_LEN); c++) step(S_WRITE, c);
    for (int c = 0; c <= int'(DRIVE); c++) step(S_WRITE, c);
    check("pre-rst count", 32'(count), 32'd4);
    check("pre-rst sda_oe", 32'(sda_oe), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async rst sda_oe", 32'(sda_oe), 32'd0);
    check("async rst count", 32'(count), 32'd0);
    check("async rst ack_ok", 32'(ack_ok), 32'd0);
    check("async rst rdata", 32'(rdata), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Randomized transactions.
    for (int t = 0; t < 16; t++) begin
      txn(7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)),
          8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), GLITCH);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
